seq_serializer: RTL and testbench



---
 rtl/seq_pkg.sv | 32 +++
 rtl/seq_serializer.sv | 186 ++++++++++++++++++
 tb/tb_seq_serializer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//
// Purpose:
//   Shared definitions for the sequence-detection slice: the serializer state
//   encoding and the default word geometry also used by the seq_det benches.
//
// Contents:
//   SEQ_WORD_WIDTH  default bits per word fed to the detector
//   SEQ_IDLE_LEVEL  default level on x when no bit is being shifted
//   seq_state_e     serializer FSM states (IDLE, SHIFT, PARITY, GAP)
//   seq_cnt_width   width of a counter that must hold 0..max_val (>= 1 bit)
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int   SEQ_WORD_WIDTH = 4;
    localparam logic SEQ_IDLE_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } seq_state_e;

    // A counter holding 0..max_val needs $clog2(max_val+1) bits; a zero-range
    // counter still gets one bit so it can be declared.
    function automatic int seq_cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer
//
// Purpose:
//   Parallel-to-serial stage feeding seq_det. Accepts WIDTH-bit words on a
//   valid/ready handshake and shifts them out MSB-first, one bit per clk,
//   optionally followed by GAP_CYCLES idle cycles per word.
//
// Optional feature (compile-time macro SEQ_SERIALIZER_PARITY_EN):
//   When defined, an extra cycle after the data bits carries the even parity
//   (XOR) of the word with x_valid=1. When undefined there is no parity logic.
//
// Parameters:
//   WIDTH       bits per word (>= 1)
//   GAP_CYCLES  idle cycles after each word (>= 0)
//   IDLE_LEVEL  level on x when no bit is being shifted
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   in_valid  in_data holds a word to send
//   in_data   word to send; bit WIDTH-1 goes out first
//   in_ready  a word can be accepted this cycle
//   x         serial bit to seq_det (registered)
//   x_valid   x carries a data or parity bit this cycle
//   busy      a frame (bits or gap) is in progress
// -----------------------------------------------------------------------------
module seq_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH      = SEQ_WORD_WIDTH,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = SEQ_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int CNT_W = seq_cnt_width(WIDTH);
    localparam int GAP_W = seq_cnt_width(GAP_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    localparam bit HAS_GAP = (GAP_CYCLES > 0);

`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam bit HAS_PARITY = 1'b1;
`else
    localparam bit HAS_PARITY = 1'b0;
`endif

    // Zero-bubble accept is only possible when no gap follows the word. The
    // accepting cycle is the last serial cycle of the frame: the last data
    // bit, or the parity bit when parity is built in.
    localparam bit ZERO_BUBBLE   = !HAS_GAP;
    localparam bit READY_ON_LOAD = ZERO_BUBBLE && !HAS_PARITY && (WIDTH == 1);

    seq_state_e       state_reg;
    logic [WIDTH-1:0] shift_reg;     // bits still to be sent, aligned to MSB
    logic [CNT_W-1:0] bit_cnt_reg;   // data bits left, including the one on x
    logic [GAP_W-1:0] gap_cnt_reg;   // gap cycles left, including current
    logic             x_reg;
    logic             x_valid_reg;
    logic             busy_reg;
    logic             in_ready_reg;
`ifdef SEQ_SERIALIZER_PARITY_EN
    logic             parity_reg;    // even parity of the word in flight
`endif

    logic accept;
    logic frame_done;                // current cycle is the final serial bit

    assign accept = in_valid && in_ready_reg;

`ifdef SEQ_SERIALIZER_PARITY_EN
    assign frame_done = (state_reg == PARITY);
`else
    assign frame_done = (state_reg == SHIFT) && (bit_cnt_reg <= CNT_ONE);
`endif

    // -------------------------------------------------------------------------
    // FSM, shifter and counters. All outputs are registered here, so in_ready
    // is precomputed one cycle ahead for the cycle it will be visible in.
    // A transfer always wins: it is only possible in IDLE or on the final
    // serial cycle, and in both cases the next cycle starts a new word.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            x_reg        <= IDLE_LEVEL;
            x_valid_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else if (accept) begin
            // MSB goes straight to x; the shifter keeps the remaining bits.
            state_reg    <= SHIFT;
            shift_reg    <= in_data << 1;
            bit_cnt_reg  <= CNT_LOAD;
            gap_cnt_reg  <= '0;
            x_reg        <= in_data[WIDTH-1];
            x_valid_reg  <= 1'b1;
            busy_reg     <= 1'b1;
            in_ready_reg <= READY_ON_LOAD;
`ifdef SEQ_SERIALIZER_PARITY_EN
            parity_reg   <= ^in_data;
`endif
        end else if (frame_done) begin
            // Word (and parity) finished with nothing new accepted.
            bit_cnt_reg <= '0;
            x_reg       <= IDLE_LEVEL;
            x_valid_reg <= 1'b0;
            if (HAS_GAP) begin
                state_reg    <= GAP;
                gap_cnt_reg  <= GAP_LOAD;
                busy_reg     <= 1'b1;
                in_ready_reg <= 1'b0;
            end else begin
                state_reg    <= IDLE;
                gap_cnt_reg  <= '0;
                busy_reg     <= 1'b0;
                in_ready_reg <= 1'b1;
            end
        end else begin
            case (state_reg)
                SHIFT: begin
                    if (bit_cnt_reg > CNT_ONE) begin
                        x_reg        <= shift_reg[WIDTH-1];
                        shift_reg    <= shift_reg << 1;
                        bit_cnt_reg  <= bit_cnt_reg - CNT_ONE;
                        // Going to the last data bit: ready there only when
                        // it is also the last serial bit of the frame.
                        in_ready_reg <= ZERO_BUBBLE && !HAS_PARITY &&
                                        (bit_cnt_reg == CNT_TWO);
                    end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                        // Last data bit done: append the parity bit.
                        state_reg    <= PARITY;
                        bit_cnt_reg  <= '0;
                        x_reg        <= parity_reg;
                        x_valid_reg  <= 1'b1;
                        busy_reg     <= 1'b1;
                        in_ready_reg <= ZERO_BUBBLE;
`endif
                    end
                end

                GAP: begin
                    if (gap_cnt_reg <= GAP_ONE) begin
                        state_reg    <= IDLE;
                        gap_cnt_reg  <= '0;
                        busy_reg     <= 1'b0;
                        in_ready_reg <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
                    end
                end

                default: begin
                    // IDLE: outputs already hold their idle values.
                end
            endcase
        end
    end

    assign x        = x_reg;
    assign x_valid  = x_valid_reg;
    assign busy     = busy_reg;
    assign in_ready = in_ready_reg;

endmodule

// File: tb/tb_seq_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_serializer
//
// Self-checking bench for seq_serializer. Three instances share the stimulus:
//   dut_g0 : WIDTH=4, GAP_CYCLES=0
//   dut_g2 : WIDTH=4, GAP_CYCLES=2
//   dut_w1 : WIDTH=1, GAP_CYCLES=0
// A phase selector picks which instance is checked. The reference model holds
// the expected future output stream as a queue of (x, x_valid) slots; an
// accepted word appends its whole frame (data bits MSB-first, optional parity,
// then gap slots). busy is "queue not empty"; in_ready is "queue empty, or
// only the final serial slot remains and there is no gap".
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;

    logic x0, xv0, busy0, rdy0;
    logic x2, xv2, busy2, rdy2;
    logic x1, xv1, busy1, rdy1;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut_g0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .x(x0), .x_valid(xv0), .busy(busy0)
    );

    seq_serializer #(.WIDTH(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut_g2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy2), .x(x2), .x_valid(xv2), .busy(busy2)
    );

    seq_serializer #(.WIDTH(1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut_w1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data[0:0]),
        .in_ready(rdy1), .x(x1), .x_valid(xv1), .busy(busy1)
    );

    int   sel = 0;
    logic x_s, xv_s, busy_s, rdy_s;

    always_comb begin
        x_s = x0; xv_s = xv0; busy_s = busy0; rdy_s = rdy0;
        case (sel)
            1: begin x_s = x2; xv_s = xv2; busy_s = busy2; rdy_s = rdy2; end
            2: begin x_s = x1; xv_s = xv1; busy_s = busy1; rdy_s = rdy1; end
            default: ;
        endcase
    end

    // ---------------- reference model ----------------
    typedef struct packed { logic x; logic xv; } slot_t;
    slot_t mq[$];
    int    m_w   = 4;
    int    m_gap = 0;
    bit    m_par = 1'b0;
    bit    last_acc = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic m_ready();
        return (mq.size() == 0) || (m_gap == 0 && mq.size() == 1);
    endfunction

    task automatic push_frame(input logic [3:0] d);
        logic p;
        p = 1'b0;
        for (int i = m_w - 1; i >= 0; i--) begin
            mq.push_back('{x: d[i], xv: 1'b1});
            p = p ^ d[i];
        end
        if (m_par) mq.push_back('{x: p, xv: 1'b1});
        for (int i = 0; i < m_gap; i++) mq.push_back('{x: 1'b0, xv: 1'b0});
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Called mid-cycle (after negedge): check this cycle's outputs, then
    // advance the model across the next rising edge.
    task automatic step(input string tag);
        logic ex, exv;
        if (mq.size() == 0) begin ex = 1'b0; exv = 1'b0; end
        else begin ex = mq[0].x; exv = mq[0].xv; end
        check($sformatf("%s.x", tag), x_s, ex);
        check($sformatf("%s.x_valid", tag), xv_s, exv);
        check($sformatf("%s.busy", tag), busy_s, mq.size() != 0);
        check($sformatf("%s.in_ready", tag), rdy_s, m_ready());
        @(posedge clk);
        last_acc = in_valid && m_ready();
        if (mq.size() != 0) void'(mq.pop_front());
        if (last_acc) push_frame(in_data);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [3:0] d, input string tag);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            step(tag);
            k++;
        end while (!last_acc && k < 40);
        n_assert++;
        assert (last_acc) else begin
            n_fail++;
            $error("FAIL %s.accept_timeout observed=0 expected=1", tag);
        end
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic do_reset(input int phase_sel, input int w, input int g);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        sel   = phase_sel;
        m_w   = w;
        m_gap = g;
        mq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef SEQ_SERIALIZER_PARITY_EN
        m_par = 1'b1;
`endif
        // ---- phase A: WIDTH=4, GAP=0 ----
        do_reset(0, 4, 0);
        idle_steps(3, "reset_idle");
        send_word(4'b1010, "single_1010");
        idle_steps(6, "single_tail");
        send_word(4'b1010, "b2b_1010");
        send_word(4'b1101, "b2b_1101");
        idle_steps(6, "b2b_tail");
        send_word(4'b1011, "word_1011");
        idle_steps(6, "word_1011_tail");

        // Reset asynchronously in the middle of the 2nd bit of 4'b1111.
        send_word(4'b1111, "abort_1111");
        step("abort_bit1");
        #2 reset = 1'b1;
        mq.delete();
        #1;
        check("async_reset.x", x_s, 1'b0);
        check("async_reset.x_valid", xv_s, 1'b0);
        check("async_reset.busy", busy_s, 1'b0);
        check("async_reset.in_ready", rdy_s, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_steps(2, "post_reset_idle");
        send_word(4'b0110, "post_reset_0110");
        idle_steps(6, "post_reset_tail");

        for (int i = 0; i < 30; i++) begin
            idle_steps($urandom_range(0, 2), "randA_idle");
            send_word(4'($urandom), $sformatf("randA_%0d", i));
        end
        idle_steps(8, "randA_tail");

        // ---- phase B: WIDTH=4, GAP=2 ----
        do_reset(1, 4, 2);
        idle_steps(2, "gap_reset_idle");
        send_word(4'b0011, "gap_0011");
        send_word(4'b1001, "gap_stall_1001");
        idle_steps(10, "gap_tail");
        for (int i = 0; i < 20; i++) begin
            idle_steps($urandom_range(0, 1), "randB_idle");
            send_word(4'($urandom), $sformatf("randB_%0d", i));
        end
        idle_steps(10, "randB_tail");

        // ---- phase C: WIDTH=1, GAP=0 ----
        do_reset(2, 1, 0);
        idle_steps(2, "w1_reset_idle");
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) idle_steps(1, "randC_idle");
            send_word(4'($urandom), $sformatf("randC_%0d", i));
        end
        idle_steps(5, "randC_tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
